obstacle_field: RTL and testbench

//  Multi-slot obstacle generator for the Dino Run playfield. It is the successor to the

---
 rtl/obstacle_field.sv | 241 ++++++++++++++++++++++++
 tb/tb_obstacle_field.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : obstacle_field                                           |
// | Description : Multi-slot obstacle generator for the Dino Run field.    |
// |               Scrolls NUM_OBS obstacles left once per frame_tick,      |
// |               spawns them at LFSR-randomised gaps, ramps the scroll    |
// |               speed over time and freezes the field on collision.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module obstacle_field #(
   parameter int          NUM_OBS     = 3,
   parameter int          SCREEN_W    = 640,
   parameter int          GROUND_V    = 400,
   parameter int          TALL_DV     = 24,
   parameter int          MIN_GAP     = 160,
   parameter int          VEL_INIT    = 4,
   parameter int          VEL_MAX     = 16,
   parameter int          RAMP_FRAMES = 600,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1,
   // Reset value of the cleared-obstacle counter; zero in normal use.
   parameter logic [15:0] PASSED_INIT = 16'h0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_tick,
   input  logic                    run_en,
   input  logic                    collide,
   output logic [10*NUM_OBS-1:0]   obstacle_h,
   output logic [10*NUM_OBS-1:0]   obstacle_v,
   output logic [NUM_OBS-1:0]      obstacle_active,
   output logic [5:0]              obstacle_hvel,
   output logic                    spawn_pulse,
   output logic [15:0]             passed_cnt,
   output logic                    frozen
);

   localparam int               IDX_W    = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
   localparam int               CNT_W    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
   localparam logic [9:0]       SPAWN_H  = 10'(SCREEN_W);
   localparam logic [9:0]       SHORT_V  = 10'(GROUND_V);
   localparam logic [9:0]       TALL_V   = 10'(GROUND_V - TALL_DV);
   localparam logic [9:0]       GAP_BASE = 10'(MIN_GAP);
   localparam logic [5:0]       HVEL_RST = 6'(VEL_INIT);
   localparam logic [5:0]       HVEL_TOP = 6'(VEL_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FROZEN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [9:0]         h_q [NUM_OBS];
   logic [9:0]         h_d [NUM_OBS];
   logic [9:0]         v_q [NUM_OBS];
   logic [9:0]         v_d [NUM_OBS];
   logic [NUM_OBS-1:0] active_q, active_d;
   logic [5:0]         hvel_q, hvel_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [9:0]         gap_q, gap_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        passed_q, passed_d;
   logic               spawn_q, spawn_d;
   logic               frozen_q, frozen_d;

   // Candidate values for a processed frame tick
   logic [9:0]         h_t [NUM_OBS];
   logic [9:0]         v_t [NUM_OBS];
   logic [NUM_OBS-1:0] act_t;
   logic [5:0]         hvel_t;
   logic [15:0]        lfsr_t;
   logic [9:0]         gap_t;
   logic [CNT_W-1:0]   cnt_t;
   logic [15:0]        passed_t;
   logic [16:0]        passed_sum;
   logic [3:0]         exits;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic               spawn_go;
   logic               tick_en;
   logic [9:0]         hvel_ext;

   assign hvel_ext = {4'b0000, hvel_q};

   // Register bank: every output and every piece of game state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         for (int i = 0; i < NUM_OBS; i++) begin
            h_q[i] <= SPAWN_H;
            v_q[i] <= SHORT_V;
         end
         active_q <= '0;
         hvel_q   <= HVEL_RST;
         lfsr_q   <= LFSR_SEED;
         gap_q    <= '0;
         cnt_q    <= '0;
         passed_q <= PASSED_INIT;
         spawn_q  <= 1'b0;
         frozen_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         v_q      <= v_d;
         active_q <= active_d;
         hvel_q   <= hvel_d;
         lfsr_q   <= lfsr_d;
         gap_q    <= gap_d;
         cnt_q    <= cnt_d;
         passed_q <= passed_d;
         spawn_q  <= spawn_d;
         frozen_q <= frozen_d;
      end
   end

   // Game FSM: decides whether the current frame tick is processed
   always_comb begin
      state_d = state_q;
      tick_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run_en) state_d = S_RUN;
         end
         S_RUN: begin
            // Collision wins over a coincident tick, so the field stops unmoved.
            if (collide)       state_d = S_FROZEN;
            else if (!run_en)  state_d = S_IDLE;
            else               tick_en = frame_tick;
         end
         S_FROZEN: begin
            state_d = S_FROZEN;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Frame-tick datapath: move, retire, spawn, gap, LFSR and speed ramp
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      exits      = '0;
      act_t      = active_q;
      for (int i = 0; i < NUM_OBS; i++) begin
         h_t[i] = h_q[i];
         v_t[i] = v_q[i];
      end

      // Only slots free before the tick qualify; a slot retiring now must wait.
      for (int i = 0; i < NUM_OBS; i++) begin
         if (!active_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      spawn_go = free_found && (gap_q <= hvel_ext);

      for (int i = 0; i < NUM_OBS; i++) begin
         if (active_q[i]) begin
            if (h_q[i] > hvel_ext) begin
               h_t[i] = h_q[i] - hvel_ext;
            end else begin
               act_t[i] = 1'b0;
               h_t[i]   = SPAWN_H;
               exits    = exits + 4'd1;
            end
         end
         if (spawn_go && (free_idx == IDX_W'(i))) begin
            act_t[i] = 1'b1;
            h_t[i]   = SPAWN_H;
            v_t[i]   = lfsr_q[0] ? TALL_V : SHORT_V;
         end
      end

      // A deferred spawn leaves the gap at zero so it retries next tick.
      if (spawn_go)
         gap_t = GAP_BASE + {3'b000, lfsr_q[7:1]};
      else if (gap_q > hvel_ext)
         gap_t = gap_q - hvel_ext;
      else
         gap_t = '0;

      passed_sum = {1'b0, passed_q} + {13'd0, exits};
      passed_t   = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];

      // x^16+x^14+x^13+x^11, right-shifting Fibonacci form
      lfsr_t = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

      if (cnt_q == CNT_LAST) begin
         cnt_t  = '0;
         hvel_t = (hvel_q < HVEL_TOP) ? hvel_q + 6'd1 : hvel_q;
      end else begin
         cnt_t  = cnt_q + 1'b1;
         hvel_t = hvel_q;
      end
   end

   // Next-state select: commit tick results, otherwise hold
   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      active_d = active_q;
      hvel_d   = hvel_q;
      lfsr_d   = lfsr_q;
      gap_d    = gap_q;
      cnt_d    = cnt_q;
      passed_d = passed_q;
      spawn_d  = 1'b0;
      frozen_d = (state_d == S_FROZEN);
      if (tick_en) begin
         h_d      = h_t;
         v_d      = v_t;
         active_d = act_t;
         hvel_d   = hvel_t;
         lfsr_d   = lfsr_t;
         gap_d    = gap_t;
         cnt_d    = cnt_t;
         passed_d = passed_t;
         spawn_d  = spawn_go;
      end else if (state_q == S_FROZEN) begin
         spawn_d  = spawn_q;
      end
   end

   generate
      for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot_out
         assign obstacle_h[10*g +: 10] = h_q[g];
         assign obstacle_v[10*g +: 10] = v_q[g];
      end
   endgenerate

   assign obstacle_active = active_q;
   assign obstacle_hvel   = hvel_q;
   assign spawn_pulse     = spawn_q;
   assign passed_cnt      = passed_q;
   assign frozen          = frozen_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_field.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_obstacle_field                                        |
// | Description : Self-checking bench for obstacle_field. Four differently |
// |               parameterised instances share one stimulus stream; a     |
// |               reference model per instance feeds a scoreboard queue,   |
// |               and a vector table adds hand-derived spot checks.        |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_obstacle_field;

   typedef struct {
      int nobs; int sw; int gv; int tdv; int mg; int vi; int vm; int rf; int pinit;
   } cfg_t;

   typedef struct {
      logic [79:0] h;
      logic [79:0] v;
      logic [7:0]  act;
      logic [5:0]  hvel;
      logic [15:0] lfsr;
      logic [9:0]  gap;
      int          cnt;
      logic [15:0] passed;
      logic        sp;
      logic        frz;
      int          st;
   } mstate_t;

   typedef struct {
      string tag;
      int reps; int rst; int run; int tick; int col;
      int a_h0; int a_v0; int a_act; int a_hv; int b_hv; int c_hv; int sp; int frz;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0, frame_tick = 1'b0, run_en = 1'b0, collide = 1'b0;

   logic [29:0] a_h, a_v, b_h, b_v, c_h, c_v;
   logic [9:0]  d_h, d_v;
   logic [2:0]  a_act, b_act, c_act;
   logic [0:0]  d_act;
   logic [5:0]  a_hv, b_hv, c_hv, d_hv;
   logic        a_sp, b_sp, c_sp, d_sp;
   logic [15:0] a_pc, b_pc, c_pc, d_pc;
   logic        a_fz, b_fz, c_fz, d_fz;

   int ntests = 0;
   int nfail  = 0;

   cfg_t    cfg [4];
   mstate_t ms  [4];
   mstate_t expq[$];
   vec_t    tbl [12];

   always #5 clk = ~clk;

   // A: defaults
   obstacle_field u_a (.clk(clk), .rst(rst), .frame_tick(frame_tick), .run_en(run_en),
      .collide(collide), .obstacle_h(a_h), .obstacle_v(a_v), .obstacle_active(a_act),
      .obstacle_hvel(a_hv), .spawn_pulse(a_sp), .passed_cnt(a_pc), .frozen(a_fz));
   // B: fast ramp, low speed cap
   obstacle_field #(.RAMP_FRAMES(4), .VEL_MAX(10)) u_b (.clk(clk), .rst(rst),
      .frame_tick(frame_tick), .run_en(run_en), .collide(collide), .obstacle_h(b_h),
      .obstacle_v(b_v), .obstacle_active(b_act), .obstacle_hvel(b_hv), .spawn_pulse(b_sp),
      .passed_cnt(b_pc), .frozen(b_fz));
   // C: fast ramp, counter preloaded near saturation
   obstacle_field #(.RAMP_FRAMES(4), .PASSED_INIT(16'hFFFE)) u_c (.clk(clk), .rst(rst),
      .frame_tick(frame_tick), .run_en(run_en), .collide(collide), .obstacle_h(c_h),
      .obstacle_v(c_v), .obstacle_active(c_act), .obstacle_hvel(c_hv), .spawn_pulse(c_sp),
      .passed_cnt(c_pc), .frozen(c_fz));
   // D: single slot, no minimum gap
   obstacle_field #(.NUM_OBS(1), .MIN_GAP(0)) u_d (.clk(clk), .rst(rst),
      .frame_tick(frame_tick), .run_en(run_en), .collide(collide), .obstacle_h(d_h),
      .obstacle_v(d_v), .obstacle_active(d_act), .obstacle_hvel(d_hv), .spawn_pulse(d_sp),
      .passed_cnt(d_pc), .frozen(d_fz));

   function automatic mstate_t mreset(cfg_t c);
      mstate_t s;
      s.h = '0; s.v = '0;
      for (int i = 0; i < c.nobs; i++) begin
         s.h[i*10 +: 10] = 10'(c.sw);
         s.v[i*10 +: 10] = 10'(c.gv);
      end
      s.act = '0; s.hvel = 6'(c.vi); s.lfsr = 16'hACE1; s.gap = '0; s.cnt = 0;
      s.passed = 16'(c.pinit); s.sp = 1'b0; s.frz = 1'b0; s.st = 0;
      return s;
   endfunction

   // Reference behaviour: one clock edge of the game
   function automatic mstate_t mstep(mstate_t s, cfg_t c, bit r, bit tk, bit re, bit co);
      mstate_t n;
      int hv, free, exits, p, hh;
      if (r) return mreset(c);
      if (s.st == 2) return s;
      n = s;
      n.sp = 1'b0;
      if (s.st == 0) begin
         if (re) n.st = 1;
         return n;
      end
      if (co) begin n.st = 2; n.frz = 1'b1; return n; end
      if (!re) begin n.st = 0; return n; end
      if (!tk) return n;
      hv = int'(s.hvel);
      free = -1; exits = 0;
      for (int i = 0; i < c.nobs; i++)
         if (!s.act[i] && free < 0) free = i;
      for (int i = 0; i < c.nobs; i++) begin
         if (s.act[i]) begin
            hh = int'(s.h[i*10 +: 10]);
            if (hh > hv) n.h[i*10 +: 10] = 10'(hh - hv);
            else begin
               n.act[i] = 1'b0; n.h[i*10 +: 10] = 10'(c.sw); exits++;
            end
         end
      end
      if (int'(s.gap) <= hv && free >= 0) begin
         n.act[free] = 1'b1;
         n.h[free*10 +: 10] = 10'(c.sw);
         n.v[free*10 +: 10] = s.lfsr[0] ? 10'(c.gv - c.tdv) : 10'(c.gv);
         n.gap = 10'(c.mg + int'(s.lfsr[7:1]));
         n.sp = 1'b1;
      end else begin
         n.gap = (int'(s.gap) > hv) ? 10'(int'(s.gap) - hv) : 10'd0;
      end
      p = int'(s.passed) + exits;
      n.passed = (p > 65535) ? 16'hFFFF : 16'(p);
      n.lfsr = {s.lfsr[0] ^ s.lfsr[2] ^ s.lfsr[3] ^ s.lfsr[5], s.lfsr[15:1]};
      if (s.cnt == c.rf - 1) begin
         n.cnt = 0;
         n.hvel = 6'((hv < c.vm) ? hv + 1 : hv);
      end else begin
         n.cnt = s.cnt + 1;
      end
      return n;
   endfunction

   task automatic chk(string nm, logic [79:0] got, logic [79:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic cmp_inst(string nm, mstate_t e, logic [79:0] h, logic [79:0] v,
                           logic [7:0] act, logic [5:0] hv, logic sp, logic [15:0] pc,
                           logic fz);
      chk({nm, ".h"},      h,           e.h);
      chk({nm, ".v"},      v,           e.v);
      chk({nm, ".active"}, 80'(act),    80'(e.act));
      chk({nm, ".hvel"},   80'(hv),     80'(e.hvel));
      chk({nm, ".spawn"},  80'(sp),     80'(e.sp));
      chk({nm, ".passed"}, 80'(pc),     80'(e.passed));
      chk({nm, ".frozen"}, 80'(fz),     80'(e.frz));
   endtask

   // Drive one cycle, push model predictions, then pop and compare after the edge
   task automatic cycle(bit r, bit re, bit tk, bit co);
      mstate_t e0, e1, e2, e3;
      @(negedge clk);
      rst = r; run_en = re; frame_tick = tk; collide = co;
      for (int k = 0; k < 4; k++) begin
         ms[k] = mstep(ms[k], cfg[k], r, tk, re, co);
         expq.push_back(ms[k]);
      end
      @(posedge clk);
      #1;
      e0 = expq.pop_front(); e1 = expq.pop_front();
      e2 = expq.pop_front(); e3 = expq.pop_front();
      cmp_inst("A", e0, 80'(a_h), 80'(a_v), 8'(a_act), a_hv, a_sp, a_pc, a_fz);
      cmp_inst("B", e1, 80'(b_h), 80'(b_v), 8'(b_act), b_hv, b_sp, b_pc, b_fz);
      cmp_inst("C", e2, 80'(c_h), 80'(c_v), 8'(c_act), c_hv, c_sp, c_pc, c_fz);
      cmp_inst("D", e3, 80'(d_h), 80'(d_v), 8'(d_act), d_hv, d_sp, d_pc, d_fz);
   endtask

   task automatic spot(vec_t t);
      if (t.a_h0  >= 0) chk({t.tag, "/a_h0"},   80'(a_h[9:0]), 80'(t.a_h0));
      if (t.a_v0  >= 0) chk({t.tag, "/a_v0"},   80'(a_v[9:0]), 80'(t.a_v0));
      if (t.a_act >= 0) chk({t.tag, "/a_act"},  80'(a_act),    80'(t.a_act));
      if (t.a_hv  >= 0) chk({t.tag, "/a_hvel"}, 80'(a_hv),     80'(t.a_hv));
      if (t.b_hv  >= 0) chk({t.tag, "/b_hvel"}, 80'(b_hv),     80'(t.b_hv));
      if (t.c_hv  >= 0) chk({t.tag, "/c_hvel"}, 80'(c_hv),     80'(t.c_hv));
      if (t.sp    >= 0) chk({t.tag, "/a_spawn"},80'(a_sp),     80'(t.sp));
      if (t.frz   >= 0) chk({t.tag, "/frozen"}, 80'(a_fz),     80'(t.frz));
   endtask

   task automatic run_vec(vec_t t);
      for (int r = 0; r < t.reps; r++) begin
         cycle(t.rst != 0, t.run != 0, 1'b0, 1'b0);
         cycle(t.rst != 0, t.run != 0, t.tick != 0, t.col != 0);
      end
      spot(t);
   endtask

   initial begin
      cfg[0] = '{3, 640, 400, 24, 160, 4, 16, 600, 0};
      cfg[1] = '{3, 640, 400, 24, 160, 4, 10, 4,   0};
      cfg[2] = '{3, 640, 400, 24, 160, 4, 16, 4,   65534};
      cfg[3] = '{1, 640, 400, 24, 0,   4, 16, 600, 0};
      for (int k = 0; k < 4; k++) ms[k] = mreset(cfg[k]);

      //          tag            reps rst run tk col  a_h0 a_v0 act hvA hvB hvC sp frz
      tbl[0]  = '{"reset",        2,  1,  0,  0, 0,   640, 400, 0,  4,  4,  4,  0, 0};
      tbl[1]  = '{"idle_to_run",  1,  0,  1,  0, 0,   640, -1,  0,  4,  4,  4,  0, 0};
      tbl[2]  = '{"first_spawn",  1,  0,  1,  1, 0,   640, 376, 1,  4,  4,  4,  1, 0};
      tbl[3]  = '{"move_10",      10, 0,  1,  1, 0,   600, 376, 1,  4,  6,  6,  0, 0};
      tbl[4]  = '{"ramp_40",      29, 0,  1,  1, 0,   484, -1,  1,  4,  10, 14, 0, 0};
      tbl[5]  = '{"run_low",      3,  0,  0,  1, 0,   484, -1,  1,  4,  10, 14, 0, 0};
      tbl[6]  = '{"resume",       1,  0,  1,  0, 0,   484, -1,  1,  4,  10, 14, 0, 0};
      tbl[7]  = '{"long_run",     120,0,  1,  1, 0,   4,   -1,  -1, 4,  10, 16, -1, 0};
      tbl[8]  = '{"collide",      1,  0,  1,  1, 1,   -1,  -1,  -1, 4,  10, 16, 0, 1};
      tbl[9]  = '{"frozen_run",   50, 0,  1,  1, 0,   -1,  -1,  -1, 4,  10, 16, 0, 1};
      tbl[10] = '{"frozen_col",   50, 0,  0,  1, 1,   -1,  -1,  -1, 4,  10, 16, 0, 1};
      tbl[11] = '{"reset_again",  2,  1,  0,  0, 0,   640, 400, 0,  4,  4,  4,  0, 0};

      for (int n = 0; n < 8; n++) run_vec(tbl[n]);

      // Single-slot field: slot0 sits at h=4 after 160 ticks and exits on tick 161
      chk("d_pre_exit_h", 80'(d_h), 80'd4);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("d_exit_active", 80'(d_act), 80'd0);
      chk("d_exit_spawn",  80'(d_sp),  80'd0);
      chk("d_exit_passed", 80'(d_pc),  80'd1);
      chk("d_exit_h",      80'(d_h),   80'd640);
      // The deferred spawn lands on the following tick
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("d_idle_spawn",  80'(d_sp),  80'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("d_respawn_spawn",  80'(d_sp),  80'd1);
      chk("d_respawn_active", 80'(d_act), 80'd1);
      chk("d_respawn_h",      80'(d_h),   80'd640);
      chk("d_passed_hold",    80'(d_pc),  80'd1);
      // Preloaded counter has cleared several obstacles by now and must stick
      chk("c_passed_sat",     80'(c_pc),  80'hFFFF);

      for (int n = 8; n < 12; n++) run_vec(tbl[n]);
      chk("c_passed_reset", 80'(c_pc), 80'hFFFE);
      chk("d_passed_reset", 80'(d_pc), 80'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
`default_nettype wire
